// File: rtl/execcmd_mc.sv
// Multi-channel command executor: fetches a 16-bit command stream from a command RAM and
// runs register writes, reads, read-modify-writes and polls on one of NCH register-bus targets.
module execcmd_mc #(
    parameter int AW       = 10,
    parameter int RAW      = 14,
    parameter int NCH      = 2,
    parameter int POLL_MAX = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_exec,
    output logic                 busy,
    output logic                 err,
    output logic [AW:0]          out_len,
    output logic [AW-1:0]        inram_address,
    output logic                 inram_re,
    input  logic [15:0]          inram_q,
    output logic [AW-1:0]        outram_address,
    output logic                 outram_we,
    output logic [15:0]          outram_d,
    output logic [RAW-1:0]       reg_addr,
    output logic [31:0]          reg_writedata,
    output logic [NCH-1:0]       reg_rd,
    output logic [NCH-1:0]       reg_wr,
    input  logic [NCH-1:0]       reg_ready,
    input  logic [32*NCH-1:0]    reg_readdata
);

    localparam int PCW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_DECODE,
        S_BUS_RD,
        S_BUS_WR,
        S_RESULT,
        S_POLL_CHK,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [AW:0]      r_ptr;
    logic [2:0]       r_wcnt;
    logic [15:0]      r_words [0:5];
    logic [31:0]      r_rdata;
    logic [31:0]      r_wdata;
    logic [PCW-1:0]   r_pcnt;
    logic             r_ridx;
    logic [AW:0]      r_out_len;
    logic             r_err;

    logic [3:0]       w_op;
    logic [3:0]       w_ch;
    logic [3:0]       w_cap_op;
    logic [2:0]       w_need;
    logic [31:0]      w_opa;
    logic [31:0]      w_opb;
    logic             w_bad;
    logic             w_ready;
    logic [31:0]      w_rdata;
    logic             w_rd_stb;
    logic             w_wr_stb;
    logic             w_match;
    logic             w_unused;

    // The header stays in slot 0 until the next header is captured, so opcode
    // and channel can be read straight from it for the whole command.
    assign w_op    = r_words[0][15:12];
    assign w_ch    = r_words[0][11:8];
    assign w_opa   = {r_words[3], r_words[2]};
    assign w_opb   = {r_words[5], r_words[4]};
    assign w_bad   = (w_op > 4'd4) || ({1'b0, w_ch} >= 5'(NCH));
    assign w_match = ((r_rdata & w_opa) == w_opb);

    assign w_unused = ^{r_words[0][7:0], r_words[1]};

    // Total words of the command, decided from the header as it arrives.
    always_comb begin
        w_cap_op = (r_wcnt == 3'd0) ? inram_q[15:12] : w_op;
        case (w_cap_op)
            4'd1:       w_need = 3'd4;
            4'd2:       w_need = 3'd2;
            4'd3, 4'd4: w_need = 3'd6;
            default:    w_need = 3'd1;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_rdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_ch == 4'(c)) begin
                w_ready = reg_ready[c];
                w_rdata = reg_readdata[32*c +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        inram_re     = 1'b0;
        outram_we    = 1'b0;
        w_rd_stb     = 1'b0;
        w_wr_stb     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_exec) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_ptr[AW]) begin
                    w_state_next = S_ERROR;
                end else begin
                    inram_re     = 1'b1;
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (r_wcnt + 3'd1 == w_need) begin
                    w_state_next = S_DECODE;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_bad) begin
                    w_state_next = S_ERROR;
                end else if (w_op == 4'd0) begin
                    w_state_next = S_IDLE;
                end else if (w_op == 4'd1) begin
                    w_state_next = S_BUS_WR;
                end else begin
                    w_state_next = S_BUS_RD;
                end
            end
            S_BUS_RD: begin
                w_rd_stb = 1'b1;
                if (w_ready) begin
                    case (w_op)
                        4'd2:    w_state_next = S_RESULT;
                        4'd3:    w_state_next = S_BUS_WR;
                        default: w_state_next = S_POLL_CHK;
                    endcase
                end
            end
            S_BUS_WR: begin
                w_wr_stb = 1'b1;
                if (w_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_RESULT: begin
                // A full result RAM stops the run before the write is issued.
                if (r_out_len[AW]) begin
                    w_state_next = S_ERROR;
                end else begin
                    outram_we = 1'b1;
                    if (r_ridx) begin
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_POLL_CHK: begin
                if (w_match) begin
                    w_state_next = S_RESULT;
                end else if (r_pcnt == PCW'(POLL_MAX)) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_state_next = S_BUS_RD;
                end
            end
            S_ERROR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_wcnt    <= '0;
            r_rdata   <= '0;
            r_wdata   <= '0;
            r_pcnt    <= '0;
            r_ridx    <= 1'b0;
            r_out_len <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_exec) begin
                        r_ptr     <= '0;
                        r_wcnt    <= '0;
                        r_out_len <= '0;
                        r_err     <= 1'b0;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < 6; i++) begin
                        if (r_wcnt == 3'(i)) begin
                            r_words[i] <= inram_q;
                        end
                    end
                    r_ptr  <= r_ptr + (AW+1)'(1);
                    r_wcnt <= (w_state_next == S_DECODE) ? 3'd0 : r_wcnt + 3'd1;
                end
                S_DECODE: begin
                    r_pcnt <= '0;
                    if (w_op == 4'd1) begin
                        r_wdata <= w_opa;
                    end
                end
                S_BUS_RD: begin
                    if (w_ready) begin
                        r_rdata <= w_rdata;
                        r_pcnt  <= r_pcnt + PCW'(1);
                        r_ridx  <= 1'b0;
                        if (w_op == 4'd3) begin
                            r_wdata <= (w_rdata & ~w_opa) | (w_opb & w_opa);
                        end
                    end
                end
                S_RESULT: begin
                    if (!r_out_len[AW]) begin
                        r_out_len <= r_out_len + (AW+1)'(1);
                        r_ridx    <= ~r_ridx;
                    end
                end
                default: begin
                end
            endcase
            if (w_state_next == S_ERROR) begin
                r_err <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_stb
        assign reg_rd[gi] = w_rd_stb && (w_ch == 4'(gi));
        assign reg_wr[gi] = w_wr_stb && (w_ch == 4'(gi));
    end

    assign busy           = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign err            = r_err;
    assign out_len        = r_out_len;
    assign inram_address  = r_ptr[AW-1:0];
    assign outram_address = r_out_len[AW-1:0];
    assign outram_d       = r_ridx ? r_rdata[31:16] : r_rdata[15:0];
    assign reg_addr       = r_words[1][RAW-1:0];
    assign reg_writedata  = r_wdata;

endmodule
